// File: rtl/gpu_pkg.sv
// Shared GPU definitions: VRAM bus widths and the write-queue FSM state type.
package gpu_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        VWQ_IDLE    = 2'd0,
        VWQ_DRAIN   = 2'd1,
        VWQ_BLOCKED = 2'd2
    } vwq_state_t;

endpackage

// File: rtl/vram_write_queue_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when
// empty are ignored so the count can never wrap.
module sync_fifo_m #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign level    = level_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/vram_write_queue.sv
// Buffers CPU VRAM writes and releases them to the GPU one per cycle, only
// while the video timing reports the writable window.
module vram_write_queue
    import gpu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_valid,
    output logic                   cpu_ready,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_data,
    input  logic                   writable,
    output logic                   vram_we,
    output logic [ADDR_W-1:0]      vram_address,
    output logic [DATA_W-1:0]      vram_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   pending,
    output logic                   overflow,
    input  logic                   overflow_clr,
    output vwq_state_t             dbg_state
);

    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    // CPU side: a write is taken when cpu_valid && cpu_ready; cpu_ready is
    // derived from the registered level only, so the 6502 never waits on a pop.
    logic               push;
    logic               drop;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic [LVL_W-1:0]   level_next;

    vwq_state_t         state_q, state_d;
    logic               vram_we_q, vram_we_d;
    logic [ADDR_W-1:0]  vram_address_q, vram_address_d;
    logic [DATA_W-1:0]  vram_data_q, vram_data_d;
    logic               overflow_q, overflow_d;

    assign cpu_ready = !fifo_full;
    assign push      = cpu_valid && cpu_ready;
    assign drop      = cpu_valid && !cpu_ready;
    assign pop       = writable && !fifo_empty;

    sync_fifo_m #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({cpu_addr, cpu_data}),
        .pop       (pop),
        .pop_data  (fifo_rd_data),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        case ({push, pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase
    end

    // BLOCKED never exits to IDLE: the level cannot fall without writable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            VWQ_IDLE: begin
                if (level != '0) begin
                    state_d = writable ? VWQ_DRAIN : VWQ_BLOCKED;
                end
            end
            VWQ_DRAIN: begin
                if (level_next == '0) begin
                    state_d = VWQ_IDLE;
                end else if (!writable) begin
                    state_d = VWQ_BLOCKED;
                end
            end
            VWQ_BLOCKED: begin
                if (writable) begin
                    state_d = VWQ_DRAIN;
                end
            end
            default: state_d = VWQ_IDLE;
        endcase
    end

    always_comb begin
        vram_we_d      = pop;
        vram_address_d = vram_address_q;
        vram_data_d    = vram_data_q;
        if (pop) begin
            vram_address_d = fifo_rd_data[ENTRY_W-1:DATA_W];
            vram_data_d    = fifo_rd_data[DATA_W-1:0];
        end
        // A drop in the same cycle as a clear wins.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= VWQ_IDLE;
            vram_we_q      <= 1'b0;
            vram_address_q <= '0;
            vram_data_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            vram_we_q      <= vram_we_d;
            vram_address_q <= vram_address_d;
            vram_data_q    <= vram_data_d;
            overflow_q     <= overflow_d;
        end
    end

    assign vram_we      = vram_we_q;
    assign vram_address = vram_address_q;
    assign vram_data    = vram_data_q;
    assign overflow     = overflow_q;
    assign pending      = (state_q == VWQ_BLOCKED);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_vram_write_queue.sv
// Directed bench for vram_write_queue: a queue-based model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_vram_write_queue;
    import gpu_pkg::*;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = VRAM_ADDR_W;
    localparam int DATA_W  = VRAM_DATA_W;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic                   clk;
    logic                   rst;
    logic                   cpu_valid;
    logic                   cpu_ready;
    logic [ADDR_W-1:0]      cpu_addr;
    logic [DATA_W-1:0]      cpu_data;
    logic                   writable;
    logic                   vram_we;
    logic [ADDR_W-1:0]      vram_address;
    logic [DATA_W-1:0]      vram_data;
    logic [$clog2(DEPTH):0] level;
    logic                   pending;
    logic                   overflow;
    logic                   overflow_clr;
    vwq_state_t             dbg_state;

    int checks = 0;
    int errors = 0;

    vram_write_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_valid    (cpu_valid),
        .cpu_ready    (cpu_ready),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .writable     (writable),
        .vram_we      (vram_we),
        .vram_address (vram_address),
        .vram_data    (vram_data),
        .level        (level),
        .pending      (pending),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model and scoreboard ----------------
    logic [ENTRY_W-1:0] exp_q[$];
    logic               model_valid = 1'b0;
    logic               e_we = 1'b0;
    logic [ADDR_W-1:0]  e_addr = '0;
    logic [DATA_W-1:0]  e_data = '0;
    logic               e_ovf = 1'b0;
    logic               e_pend = 1'b0;

    initial begin
        logic [ENTRY_W-1:0] ent;
        logic               m_pop;
        logic               m_ready;
        forever begin
            @(posedge clk);
            if (!rst) begin
                exp_q.delete();
                e_we        = 1'b0;
                e_addr      = '0;
                e_data      = '0;
                e_ovf       = 1'b0;
                e_pend      = 1'b0;
                model_valid = 1'b1;
            end else if (model_valid) begin
                m_ready = (exp_q.size() != DEPTH);
                m_pop   = writable && (exp_q.size() != 0);
                e_pend  = !writable && (exp_q.size() != 0);
                if (m_pop) begin
                    ent    = exp_q.pop_front();
                    e_we   = 1'b1;
                    e_addr = ent[ENTRY_W-1:DATA_W];
                    e_data = ent[DATA_W-1:0];
                end else begin
                    e_we = 1'b0;
                end
                if (cpu_valid && m_ready) begin
                    exp_q.push_back({cpu_addr, cpu_data});
                end
                if (cpu_valid && !m_ready) begin
                    e_ovf = 1'b1;
                end else if (overflow_clr) begin
                    e_ovf = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                check("m_we",      32'(vram_we),   32'(e_we));
                check("m_addr",    32'(vram_address), 32'(e_addr));
                check("m_data",    32'(vram_data), 32'(e_data));
                check("m_level",   32'(level),     32'(exp_q.size()));
                check("m_ready",   32'(cpu_ready), 32'(exp_q.size() != DEPTH));
                check("m_pending", 32'(pending),   32'(e_pend));
                check("m_ovf",     32'(overflow),  32'(e_ovf));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic w, input logic c);
        cpu_valid    = v;
        cpu_addr     = a;
        cpu_data     = d;
        writable     = w;
        overflow_clr = c;
        @(negedge clk);
    endtask

    task automatic idle(input logic w);
        cycle(1'b0, '0, '0, w, 1'b0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int strobes;

        rst = 1'b0;
        cpu_valid = 1'b0;
        cpu_addr = '0;
        cpu_data = '0;
        writable = 1'b1;
        overflow_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Idle with writable high
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            check("idle_we", 32'(vram_we), 32'd0);
            check("idle_level", 32'(level), 32'd0);
            check("idle_ready", 32'(cpu_ready), 32'd1);
            check("idle_ovf", 32'(overflow), 32'd0);
        end

        // Single write: strobe two cycles after the push
        cycle(1'b1, 13'h123, 8'hA5, 1'b1, 1'b0);
        check("lat_we_early", 32'(vram_we), 32'd0);
        check("lat_level1", 32'(level), 32'd1);
        idle(1'b1);
        check("lat_we", 32'(vram_we), 32'd1);
        check("lat_addr", 32'(vram_address), 32'h123);
        check("lat_data", 32'(vram_data), 32'hA5);
        check("lat_level0", 32'(level), 32'd0);
        idle(1'b1);
        check("lat_we_once", 32'(vram_we), 32'd0);

        // Fill while blocked, then overflow, then drain in order
        for (int i = 0; i < 16; i++) begin
            a = ADDR_W'(i);
            d = DATA_W'(i);
            cycle(1'b1, a, d ^ 8'hFF, 1'b0, 1'b0);
            check("fill_no_we", 32'(vram_we), 32'd0);
        end
        check("full_level", 32'(level), 32'd16);
        check("full_ready", 32'(cpu_ready), 32'd0);
        check("full_pending", 32'(pending), 32'd1);
        cycle(1'b1, 13'h1FF, 8'h77, 1'b0, 1'b0);
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_level", 32'(level), 32'd16);
        check("drop_no_we", 32'(vram_we), 32'd0);
        for (int i = 0; i < 16; i++) begin
            idle(1'b1);
            d = DATA_W'(i);
            check("drain_we", 32'(vram_we), 32'd1);
            check("drain_addr", 32'(vram_address), 32'(i));
            check("drain_data", 32'(vram_data), 32'(d ^ 8'hFF));
        end
        idle(1'b1);
        check("drain_done_we", 32'(vram_we), 32'd0);
        idle(1'b1);
        check("drain_state", 32'(dbg_state), 32'(VWQ_IDLE));
        check("drain_pending", 32'(pending), 32'd0);

        // Window closes after 5 of 10 pops
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 13'h200 + ADDR_W'(i), DATA_W'(i), 1'b0, 1'b0);
        end
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            if (vram_we) strobes++;
            check("win_addr", 32'(vram_address), 32'h200 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            if (vram_we) strobes++;
        end
        check("win_strobes", 32'(strobes), 32'd5);
        check("win_level", 32'(level), 32'd5);
        check("win_pending", 32'(pending), 32'd1);
        check("win_state", 32'(dbg_state), 32'(VWQ_BLOCKED));
        for (int i = 5; i < 10; i++) begin
            idle(1'b1);
            check("win2_we", 32'(vram_we), 32'd1);
            check("win2_addr", 32'(vram_address), 32'h200 + 32'(i));
            check("win2_data", 32'(vram_data), 32'(i));
        end
        idle(1'b1);
        idle(1'b1);
        check("win2_level", 32'(level), 32'd0);

        // Push and pop together, then overflow clear priority
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 13'h300 + ADDR_W'(i), 8'h30 + DATA_W'(i), 1'b0, 1'b0);
        end
        check("pp_level_before", 32'(level), 32'd3);
        cycle(1'b1, 13'h303, 8'h33, 1'b1, 1'b0);
        check("pp_level", 32'(level), 32'd3);
        check("pp_addr", 32'(vram_address), 32'h300);
        for (int i = 4; i < 17; i++) begin
            cycle(1'b1, 13'h300 + ADDR_W'(i), 8'h30 + DATA_W'(i), 1'b0, 1'b0);
        end
        check("pp_full", 32'(level), 32'd16);
        cycle(1'b1, 13'h3FF, 8'hEE, 1'b0, 1'b1);
        check("clr_drop_ovf", 32'(overflow), 32'd1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check("clr_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 18; i++) begin
            idle(1'b1);
        end
        check("pp_drained", 32'(level), 32'd0);

        // Reset in the middle of a drain
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 13'h400 + ADDR_W'(i), DATA_W'(i), 1'b0, 1'b0);
        end
        cycle(1'b1, 13'h4FF, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
        end
        check("rst_pre_level", 32'(level), 32'd8);
        check("rst_pre_ovf", 32'(overflow), 32'd1);
        rst = 1'b0;
        cycle(1'b1, 13'h555, 8'h55, 1'b1, 1'b0);
        rst = 1'b1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_we", 32'(vram_we), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_ready", 32'(cpu_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(VWQ_IDLE));
        cycle(1'b1, 13'h000, 8'h5A, 1'b1, 1'b0);
        check("post_rst_we_early", 32'(vram_we), 32'd0);
        idle(1'b1);
        check("post_rst_we", 32'(vram_we), 32'd1);
        check("post_rst_addr", 32'(vram_address), 32'h000);
        check("post_rst_data", 32'(vram_data), 32'h5A);
        idle(1'b1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
